arilla_bus_arbiter: RTL and testbench
=====================================

Name: arilla_bus_arbiter

Overview:
- Shares one arilla bus slave segment between NumMasters requesters (core fetch, core LSU, debug module).
- Grants the segment with round-robin arbitration and holds the grant until the transfer completes, the master abandons it, or a timeout fires.
- Sits between the masters' bus ports and the shared interconnect and memory segment.
- Converts the shared bidirectional data of the bus into separate write and read paths on its flattened ports.

Parameters:
- NumMasters, 2, number of requesters (2..8).
- DataWidth, 32, bus data width in bits, a multiple of 8.
- AddressWidth, 32, byte address width. The word address width is AW = AddressWidth - $clog2(DataWidth/8).
- TimeoutCycles, 255, number of BUSY cycles without s_available before a forced completion. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m_read  in  NumMasters  per-master read request.
- m_write  in  NumMasters  per-master write request.
- m_address  in  NumMasters*AW  per-master word address, packed with master i at [i*AW +: AW].
- m_byte_enable  in  NumMasters*(DataWidth/8)  per-master byte enables, packed the same way.
- m_wdata  in  NumMasters*DataWidth  per-master write data, packed the same way.
- m_rdata  out  DataWidth  read data, broadcast to all masters.
- m_available  out  NumMasters  per-master completion strobe.
- m_intercept  out  NumMasters  per-master copy of s_intercept, gated by grant.
- m_error  out  NumMasters  per-master timeout strobe.
- s_read  out  1  read request to the slave segment.
- s_write  out  1  write request to the slave segment.
- s_address  out  AW  word address to the slave segment.
- s_byte_enable  out  DataWidth/8  byte enables to the slave segment.
- s_wdata  out  DataWidth  write data to the slave segment.
- s_rdata  in  DataWidth  read data from the slave segment.
- s_available  in  1  slave completion.
- s_intercept  in  1  a slave has claimed the address.

Behaviour:
- Request rule: master i requests when m_read[i] | m_write[i]. It holds the request and its address, byte enable and data stable until it sees m_available[i]=1. Asserting m_read and m_write together is illegal; the arbiter forwards both unchanged.
- State machine: IDLE and BUSY, plus a registered grant index g, a round-robin pointer p and a timeout counter tcnt.
- IDLE:
  - All s_* outputs are 0.
  - If any request is present, select the first requester at or after p, scanning cyclically (p, p+1, ... NumMasters-1, 0, ...).
  - Register it into g, clear tcnt and go to BUSY.
  - Arbitration latency is 1 cycle.
- BUSY, slave drive:
  - s_read, s_write, s_address, s_byte_enable and s_wdata are driven combinationally from master g.
  - m_intercept[g] = s_intercept. All other bits of m_intercept are 0.
- BUSY, completion: when s_available=1, m_available[g]=1 in that same cycle and m_rdata = s_rdata. Then p <= (g+1) mod NumMasters and the next state is IDLE.
- BUSY, abandon: if master g drops both m_read[g] and m_write[g] while s_available=0:
  - go to IDLE, with no strobe and p unchanged;
  - s_read and s_write are 0 in that cycle, because they follow master g.
- BUSY, timeout:
  - tcnt increments on every BUSY cycle with s_available=0.
  - When TimeoutCycles != 0 and tcnt reaches TimeoutCycles-1 with s_available still 0, the next cycle asserts m_available[g]=1 and m_error[g]=1 for one cycle, with m_rdata=0.
  - In that cycle s_read and s_write are forced to 0. Then p advances as for a normal completion and the next state is IDLE.
- Simultaneous events:
  - s_available in the timeout cycle: a normal completion, with no error.
  - s_available together with an abandon: counts as a completion.
- Gaps: at least one IDLE cycle separates consecutive grants.
- m_rdata: equals s_rdata only in a completion cycle, otherwise 0.
- m_available and m_error: strobes, at most one bit set, only for g.
- Reset:
  - State IDLE, g=0, p=0, tcnt=0.
  - All outputs are 0 in the cycle after rst is sampled high.
  - A transfer in progress is dropped with no strobe. The slave is responsible for tolerating s_read or s_write deasserting mid-transfer.
- Widths: tcnt is $clog2(TimeoutCycles+1) bits wide and saturates, so it never wraps.

Test Plan:
- Single read: master 1 reads address 0x40, slave returns 0xDEADBEEF with s_available 2 cycles after s_read rises.
  -> s_read rises 1 cycle after the request; m_available[1] pulses once with m_rdata=0xDEADBEEF; next grant goes to master 0 first.
- Contention: masters 0 and 1 issue continuous writes, slave has 0-wait s_available.
  -> Grants alternate 0,1,0,1 with one IDLE cycle between each; s_wdata and s_byte_enable always match the granted master.
- Timeout: TimeoutCycles=4, master 0 reads, slave never asserts s_available.
  -> After 4 BUSY cycles, m_available[0]=m_error[0]=1 for 1 cycle with m_rdata=0; then IDLE; p=1.
- Abandon: master 1 is granted, then drops m_write after 1 cycle with s_available=0.
  -> s_write=0 in that same cycle; no strobe; IDLE; master 1 wins again if it re-requests (p unchanged).
- Reset mid-transfer: rst is asserted in BUSY on the cycle s_available=1.
  -> No m_available strobe after reset is sampled; all outputs are 0; next arbitration starts from master 0.
- Intercept: granted master 2 of 3, s_intercept=1.
  -> m_intercept=3'b100; with no grant, m_intercept=0 regardless of s_intercept.

Source files
------------

// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter that shares one arilla bus slave segment between NumMasters requesters.
// The grant is held until completion, abandon or timeout. The slave side is driven from the grantee.
module arilla_bus_arbiter #(
  parameter int unsigned NumMasters    = 2,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 255,
  localparam int unsigned BeWidth      = DataWidth / 8,
  localparam int unsigned Aw           = AddressWidth - $clog2(BeWidth)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumMasters-1:0]           m_read_i,
  input  logic [NumMasters-1:0]           m_write_i,
  input  logic [NumMasters*Aw-1:0]        m_address_i,
  input  logic [NumMasters*BeWidth-1:0]   m_byte_enable_i,
  input  logic [NumMasters*DataWidth-1:0] m_wdata_i,
  output logic [DataWidth-1:0]            m_rdata_o,
  output logic [NumMasters-1:0]           m_available_o,
  output logic [NumMasters-1:0]           m_intercept_o,
  output logic [NumMasters-1:0]           m_error_o,
  output logic                            s_read_o,
  output logic                            s_write_o,
  output logic [Aw-1:0]                   s_address_o,
  output logic [BeWidth-1:0]              s_byte_enable_o,
  output logic [DataWidth-1:0]            s_wdata_o,
  input  logic [DataWidth-1:0]            s_rdata_i,
  input  logic                            s_available_i,
  input  logic                            s_intercept_i
);

  localparam int unsigned IdxW  = $clog2(NumMasters);
  localparam int unsigned TcntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [TcntW-1:0] TcntLimit = TcntW'(TimeoutCycles);
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(NumMasters - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       g_q;
  logic [IdxW-1:0]       p_q;
  logic [TcntW-1:0]      tcnt_q;

  logic [NumMasters-1:0] req;
  logic [IdxW-1:0]       pick;
  logic [IdxW-1:0]       g_next;
  int unsigned           scan_idx;
  logic                  any_req;
  logic                  busy;
  logic                  g_req;
  logic                  tmo_reached;
  logic                  complete;
  logic                  abandon;
  logic                  timeout;

  assign req     = m_read_i | m_write_i;
  assign any_req = |req;
  assign busy    = (state_q == StBusy);
  assign g_req   = req[g_q];
  assign g_next  = (g_q == LastIdx) ? '0 : g_q + 1'b1;

  assign tmo_reached = (TimeoutCycles != 0) && (tcnt_q >= TcntLimit);

  // A completion wins over abandon and timeout; an abandon suppresses the timeout strobe.
  assign complete = busy & s_available_i;
  assign abandon  = busy & ~s_available_i & ~g_req;
  assign timeout  = busy & ~s_available_i & g_req & tmo_reached;

  // Scan from the highest offset down so the nearest requester at or after p_q wins.
  always_comb begin
    scan_idx = 0;
    pick     = p_q;
    for (int k = NumMasters - 1; k >= 0; k--) begin
      scan_idx = (int'(p_q) + k) % NumMasters;
      if (req[scan_idx]) begin
        pick = IdxW'(scan_idx);
      end
    end
  end

  always_comb begin
    m_rdata_o       = '0;
    m_available_o   = '0;
    m_intercept_o   = '0;
    m_error_o       = '0;
    s_read_o        = 1'b0;
    s_write_o       = 1'b0;
    s_address_o     = '0;
    s_byte_enable_o = '0;
    s_wdata_o       = '0;
    if (busy) begin
      s_read_o             = m_read_i[g_q] & ~timeout;
      s_write_o            = m_write_i[g_q] & ~timeout;
      s_address_o          = m_address_i[int'(g_q)*Aw +: Aw];
      s_byte_enable_o      = m_byte_enable_i[int'(g_q)*BeWidth +: BeWidth];
      s_wdata_o            = m_wdata_i[int'(g_q)*DataWidth +: DataWidth];
      m_intercept_o[g_q]   = s_intercept_i;
      m_available_o[g_q]   = complete | timeout;
      m_error_o[g_q]       = timeout;
      if (complete) begin
        m_rdata_o = s_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      g_q     <= '0;
      p_q     <= '0;
      tcnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            g_q     <= pick;
            tcnt_q  <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (complete || timeout) begin
            p_q     <= g_next;
            state_q <= StIdle;
          end else if (abandon) begin
            state_q <= StIdle;
          end else if (tcnt_q != '1) begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Directed bench for arilla_bus_arbiter: a scoreboard queue of expected strobes is popped by a
// monitor whenever the DUT raises m_available or m_error; bus-side drive is checked inline.
module tb_arilla_bus_arbiter;

  localparam int unsigned N   = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned AWB = 32;
  localparam int unsigned TO  = 4;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned AW  = AWB - $clog2(BW);

  typedef struct {
    int          idx;
    logic [DW-1:0] rdata;
    bit          err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_read, m_write;
  logic [N*AW-1:0] m_address;
  logic [N*BW-1:0] m_byte_enable;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_available, m_intercept, m_error;
  logic            s_read, s_write;
  logic [AW-1:0]   s_address;
  logic [BW-1:0]   s_byte_enable;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic            s_available, s_intercept;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  arilla_bus_arbiter #(
    .NumMasters   (N),
    .DataWidth    (DW),
    .AddressWidth (AWB),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .m_read_i       (m_read),
    .m_write_i      (m_write),
    .m_address_i    (m_address),
    .m_byte_enable_i(m_byte_enable),
    .m_wdata_i      (m_wdata),
    .m_rdata_o      (m_rdata),
    .m_available_o  (m_available),
    .m_intercept_o  (m_intercept),
    .m_error_o      (m_error),
    .s_read_o       (s_read),
    .s_write_o      (s_write),
    .s_address_o    (s_address),
    .s_byte_enable_o(s_byte_enable),
    .s_wdata_o      (s_wdata),
    .s_rdata_i      (s_rdata),
    .s_available_i  (s_available),
    .s_intercept_i  (s_intercept)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    m_read[i]                 = rd;
    m_write[i]                = wr;
    m_address[i*AW +: AW]     = a;
    m_byte_enable[i*BW +: BW] = be;
    m_wdata[i*DW +: DW]       = d;
  endtask

  task automatic push_exp(input int idx, input logic [DW-1:0] rd, input bit err);
    exp_t e;
    e.idx   = idx;
    e.rdata = rd;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ctl"}, 128'({s_read, s_write, m_available, m_error, m_intercept}), 128'(0));
    chk({name, "_bus"}, 128'({s_address, s_byte_enable, s_wdata, m_rdata}), 128'(0));
  endtask

  task automatic chk_drive(input string name, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [BW-1:0] be, input logic [DW-1:0] d);
    chk({name, "_rw"}, 128'({s_read, s_write}), 128'({rd, wr}));
    chk({name, "_addr"}, 128'(s_address), 128'(a));
    chk({name, "_be"}, 128'(s_byte_enable), 128'(be));
    chk({name, "_wdata"}, 128'(s_wdata), 128'(d));
  endtask

  // Strobes seen while rst is high belong to a transfer that reset is dropping.
  always @(negedge clk) begin : monitor
    exp_t         e;
    logic [N-1:0] one;
    if (rst === 1'b0 && (m_available !== '0 || m_error !== '0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got avail=%b err=%b expected none", m_available,
                 m_error);
      end else begin
        e = exp_q.pop_front();
        one = '0;
        one[e.idx] = 1'b1;
        chk("strobe_avail", 128'(m_available), 128'(one));
        chk("strobe_error", 128'(m_error), e.err ? 128'(one) : 128'(0));
        chk("strobe_rdata", 128'(m_rdata), 128'(e.rdata));
      end
    end
  end

  initial begin
    rst           = 1'b1;
    m_read        = 3'b011;
    m_write       = '0;
    m_address     = '0;
    m_byte_enable = '0;
    m_wdata       = '0;
    s_rdata       = 32'h1234_5678;
    s_available   = 1'b1;
    s_intercept   = 1'b1;
    tick();
    tick();
    at_neg();
    chk_idle("reset");

    tick();
    rst         = 1'b0;
    m_read      = '0;
    s_available = 1'b0;
    s_intercept = 1'b0;
    s_rdata     = '0;

    // Single read by master 1, slave answers two cycles after s_read rises.
    tick();
    set_m(1, 1'b1, 1'b0, 30'h40, 4'hF, 32'h0);
    push_exp(1, 32'hDEAD_BEEF, 1'b0);
    at_neg();
    chk("rd_latency", 128'(s_read), 128'(0));
    tick();
    at_neg();
    chk_drive("rd_grant", 1'b1, 1'b0, 30'h40, 4'hF, 32'h0);
    tick();
    at_neg();
    chk_drive("rd_wait", 1'b1, 1'b0, 30'h40, 4'hF, 32'h0);
    tick();
    s_available = 1'b1;
    s_rdata     = 32'hDEAD_BEEF;
    at_neg();
    chk("rd_done_sread", 128'(s_read), 128'(1));

    // Contention: masters 0 and 1 write continuously, zero-wait slave.
    tick();
    set_m(1, 1'b0, 1'b1, 30'h104, 4'hC, 32'hB1B1_0002);
    set_m(0, 1'b0, 1'b1, 30'h100, 4'h3, 32'hA0A0_0001);
    s_rdata = 32'h5A5A_0003;
    for (int k = 0; k < 4; k++) push_exp(k % 2, 32'h5A5A_0003, 1'b0);
    for (int k = 0; k < 8; k++) begin
      at_neg();
      if (k % 2 == 0) chk_idle("ct_gap");
      else if (((k >> 1) & 1) == 0) chk_drive("ct_m0", 1'b0, 1'b1, 30'h100, 4'h3, 32'hA0A0_0001);
      else chk_drive("ct_m1", 1'b0, 1'b1, 30'h104, 4'hC, 32'hB1B1_0002);
      tick();
    end
    set_m(0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
    s_available = 1'b0;
    s_rdata     = '0;
    at_neg();
    chk_idle("ct_done");

    // Timeout: master 0 reads, slave never answers.
    tick();
    set_m(0, 1'b1, 1'b0, 30'h80, 4'hF, 32'h0);
    s_rdata = 32'hFFFF_FFFF;
    push_exp(0, 32'h0, 1'b1);
    at_neg();
    chk("to_latency", 128'(s_read), 128'(0));
    tick();
    for (int j = 0; j < 4; j++) begin
      at_neg();
      chk("to_wait_sread", 128'(s_read), 128'(1));
      tick();
    end
    at_neg();
    chk("to_fire_sread", 128'(s_read), 128'(0));
    tick();
    set_m(0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
    s_rdata = '0;
    at_neg();
    chk_idle("to_done");

    // Abandon: pointer is now 1, so master 1 wins over master 0.
    tick();
    set_m(0, 1'b1, 1'b0, 30'h110, 4'hF, 32'h0);
    set_m(1, 1'b0, 1'b1, 30'h200, 4'h5, 32'h1357_9BDF);
    at_neg();
    chk("ab_latency", 128'(s_write), 128'(0));
    tick();
    at_neg();
    chk_drive("ab_grant", 1'b0, 1'b1, 30'h200, 4'h5, 32'h1357_9BDF);
    tick();
    set_m(1, 1'b0, 1'b0, 30'h200, 4'h5, 32'h1357_9BDF);
    at_neg();
    chk("ab_drop_rw", 128'({s_read, s_write}), 128'(0));
    tick();
    set_m(1, 1'b0, 1'b1, 30'h200, 4'h5, 32'h1357_9BDF);
    at_neg();
    chk_idle("ab_idle");
    tick();
    at_neg();
    chk_drive("ab_rewin", 1'b0, 1'b1, 30'h200, 4'h5, 32'h1357_9BDF);

    // Reset on the completion cycle: no strobe, pointer back to 0.
    tick();
    rst         = 1'b1;
    s_available = 1'b1;
    s_rdata     = 32'h0BAD_0BAD;
    at_neg();
    tick();
    rst = 1'b0;
    set_m(1, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
    set_m(2, 1'b1, 1'b0, 30'h300, 4'hF, 32'h0);
    at_neg();
    chk_idle("rst_out");
    tick();
    s_available = 1'b0;
    s_intercept = 1'b1;
    at_neg();
    chk_drive("rst_rearb", 1'b1, 1'b0, 30'h110, 4'hF, 32'h0);
    chk("icpt_g0", 128'(m_intercept), 128'(3'b001));

    // Intercept gating and completion landing on the timeout cycle.
    tick();
    push_exp(0, 32'hCAFE_F00D, 1'b0);
    s_available = 1'b1;
    s_rdata     = 32'hCAFE_F00D;
    at_neg();
    tick();
    set_m(0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
    s_available = 1'b0;
    s_rdata     = '0;
    at_neg();
    chk_idle("icpt_idle");
    tick();
    at_neg();
    chk("icpt_g2", 128'(m_intercept), 128'(3'b100));
    chk_drive("g2_drive", 1'b1, 1'b0, 30'h300, 4'hF, 32'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      at_neg();
      chk("g2_wait_sread", 128'(s_read), 128'(1));
    end
    tick();
    s_available = 1'b1;
    s_rdata     = 32'h600D_0002;
    push_exp(2, 32'h600D_0002, 1'b0);
    at_neg();
    tick();
    set_m(2, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
    s_available = 1'b0;
    s_intercept = 1'b0;
    s_rdata     = '0;
    at_neg();
    chk_idle("final");
    tick();
    at_neg();
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
